sprite_mem_arbiter: RTL and testbench
=====================================

Name: sprite_mem_arbiter

Overview:
- Owns the single port of the sprite attribute RAM.
- Shares that port between two requesters:
  - the EX-stage sprite path (CPU): sprite index, attribute select and 8-bit write data, with re/we strobes.
  - the sprite renderer: read-only attribute fetches.
- Renderer has default priority because of display deadlines. A starvation counter bounds CPU wait.
- Generates the CPU pipeline stall and returns read data to both requesters.

Parameters:
- IDX_W, 8, sprite index width (CPU sprite_addr).
- ATTR_W, 4, attribute select width (CPU sprite_action).
- DATA_W, 8, attribute data width.
- MAX_WAIT, 4, number of consecutive CPU-denied cycles that forces a CPU grant.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_re  in  1  CPU read request.
- cpu_we  in  1  CPU write request; wins if asserted together with cpu_re.
- cpu_idx  in  IDX_W  CPU sprite index.
- cpu_attr  in  ATTR_W  CPU attribute select.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  hold the EX stage; combinational.
- cpu_rvalid  out  1  CPU read data valid this cycle.
- cpu_rdata  out  DATA_W  CPU read data; holds the last value read.
- ren_req  in  1  renderer read request; held until ren_gnt.
- ren_addr  in  IDX_W+ATTR_W  renderer address.
- ren_gnt  out  1  renderer request issued this cycle.
- ren_rvalid  out  1  renderer data valid this cycle.
- ren_rdata  out  DATA_W  renderer read data (mem_rdata pass-through).
- mem_addr  out  IDX_W+ATTR_W  RAM address, = {idx, attr} for CPU.
- mem_re  out  1  RAM read enable.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_re.

Behaviour:
- States:
  - IDLE: port free.
  - CPU_RD: CPU read data returning.
  - REN_RD: renderer read data returning.
- Issue happens only in IDLE. At most one RAM access per cycle. No issue in CPU_RD or REN_RD.
- cpu_req = cpu_re | cpu_we.
- Arbitration in IDLE:
  - cpu_pri = (wait_cnt == MAX_WAIT).
  - If cpu_req and (cpu_pri or !ren_req): CPU granted.
  - Else if ren_req: renderer granted.
- CPU write grant:
  - mem_we=1, mem_addr={cpu_idx,cpu_attr}, mem_wdata=cpu_wdata, cpu_stall=0 in the same cycle.
  - State stays IDLE. Single-cycle write.
- CPU read grant:
  - mem_re=1, cpu_stall=1, next state CPU_RD.
- CPU_RD state:
  - cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_stall=0.
  - rdata register captures mem_rdata.
  - Next state IDLE.
- Renderer grant:
  - ren_gnt=1, mem_re=1, mem_addr=ren_addr, next state REN_RD.
- REN_RD state: ren_rvalid=1, next state IDLE.
- cpu_stall=1 whenever cpu_req=1 and the CPU is not granted in IDLE, including while in REN_RD. The one exception is CPU_RD, where cpu_stall=0.
- Read latency:
  - CPU read: 2 cycles (grant + data) when uncontended.
  - Renderer: data on the cycle after ren_gnt.
- wait_cnt:
  - 0..MAX_WAIT. Increments each cycle cpu_req=1 and cpu_stall=1 outside CPU_RD, saturating at MAX_WAIT.
  - Clears on CPU grant, and when cpu_req=0.
- Worst-case CPU wait is bounded at roughly 2*MAX_WAIT+2 cycles.
- mem_* outputs are combinational from state and requests. In all non-issue cycles, mem_re=0 and mem_we=0; mem_addr/mem_wdata are don't-care.
- Reset:
  - Synchronous. State goes to IDLE, wait_cnt=0, cpu_rdata=0.
  - All strobes are 0 during reset: cpu_rvalid, ren_rvalid, ren_gnt, mem_re, mem_we.
  - cpu_stall is 0 while rst=1.
  - A read in flight when reset asserts is dropped; no rvalid follows.
- Simultaneous cpu_re and cpu_we: treated as a write; no read is performed.

Test Plan:
1. Reset, then CPU write idx=8'h12, attr=4'h3, wdata=8'hA5, ren_req=0 -> same cycle: mem_we=1, mem_addr=12'h123, mem_wdata=A5, cpu_stall=0. State stays IDLE.
2. CPU read of the same address -> cycle0: mem_re=1, cpu_stall=1. Cycle1: cpu_rvalid=1, cpu_rdata=A5, cpu_stall=0. cpu_rdata holds A5 afterwards.
3. ren_req and cpu_re asserted together in IDLE with wait_cnt=0 -> renderer granted (ren_gnt=1), ren_rvalid the next cycle. CPU stalled, wait_cnt increments.
4. ren_req held continuously, cpu_re held, MAX_WAIT=4 -> renderer wins until wait_cnt reaches 4. The next IDLE grants the CPU despite ren_req=1, and wait_cnt clears to 0.
5. CPU read granted, rst asserted in the CPU_RD cycle -> cpu_rvalid=0 that cycle. After reset: state IDLE, cpu_rdata=0, no mem strobes.
6. cpu_re=1 and cpu_we=1 with wdata=8'h3C -> single-cycle write (mem_we=1, mem_re=0), no cpu_rvalid. A subsequent read returns 3C.

Source files
------------

// File: rtl/sprite_mem_arbiter.sv
// Sprite attribute RAM port arbiter.
// The renderer has priority by default. A CPU wait counter forces a CPU
// grant once MAX_WAIT consecutive stalled cycles have built up.
module sprite_mem_arbiter #(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned ATTR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_re,
  input  logic                    cpu_we,
  input  logic [IDX_W-1:0]        cpu_idx,
  input  logic [ATTR_W-1:0]       cpu_attr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_stall,
  output logic                    cpu_rvalid,
  output logic [DATA_W-1:0]       cpu_rdata,
  input  logic                    ren_req,
  input  logic [IDX_W+ATTR_W-1:0] ren_addr,
  output logic                    ren_gnt,
  output logic                    ren_rvalid,
  output logic [DATA_W-1:0]       ren_rdata,
  output logic [IDX_W+ATTR_W-1:0] mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int unsigned ADDR_W = IDX_W + ATTR_W;
  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CPU_RD = 2'd1;
  localparam logic [1:0] S_REN_RD = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_rdata;

  logic w_cpu_req;
  logic w_cpu_pri;
  logic w_cpu_win;
  logic w_idle;
  logic w_cpu_gnt;

  assign w_cpu_req = cpu_re | cpu_we;
  assign w_cpu_pri = (r_wait_cnt == CNT_W'(MAX_WAIT));
  assign w_cpu_win = w_cpu_req & (w_cpu_pri | ~ren_req);
  assign w_idle    = ~rst & (r_state == S_IDLE);
  assign w_cpu_gnt = w_idle & w_cpu_win;

  assign ren_rdata = mem_rdata;

  // Next-state decode and all port-side strobes; everything is forced quiet in reset.
  always_comb begin
    w_state_nxt = r_state;
    cpu_stall   = 1'b0;
    cpu_rvalid  = 1'b0;
    cpu_rdata   = r_rdata;
    ren_gnt     = 1'b0;
    ren_rvalid  = 1'b0;
    mem_addr    = {cpu_idx, cpu_attr};
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = cpu_wdata;

    if (rst) begin
      w_state_nxt = S_IDLE;
      cpu_rdata   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cpu_win) begin
            if (cpu_we) begin
              mem_we = 1'b1;
            end else begin
              mem_re      = 1'b1;
              cpu_stall   = 1'b1;
              w_state_nxt = S_CPU_RD;
            end
          end else begin
            cpu_stall = w_cpu_req;
            if (ren_req) begin
              ren_gnt     = 1'b1;
              mem_re      = 1'b1;
              mem_addr    = ren_addr;
              w_state_nxt = S_REN_RD;
            end
          end
        end
        S_CPU_RD: begin
          cpu_rvalid  = 1'b1;
          cpu_rdata   = mem_rdata;
          w_state_nxt = S_IDLE;
        end
        S_REN_RD: begin
          ren_rvalid  = 1'b1;
          cpu_stall   = w_cpu_req;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, CPU read-data holding register and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CPU_RD) begin
        r_rdata <= mem_rdata;
      end
      if (w_cpu_gnt || !w_cpu_req) begin
        r_wait_cnt <= '0;
      end else if (cpu_stall && (r_state != S_CPU_RD) && !w_cpu_pri) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  logic [ADDR_W-1:0] w_unused_addr_chk;
  assign w_unused_addr_chk = ren_addr;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: a cycle-by-cycle vector table with hand-derived
// expectations, a behavioural RAM, and read-data scoreboards per requester.
module tb_sprite_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_idx;
  logic [3:0]  cpu_attr;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ren_req;
  logic [11:0] ren_addr;
  logic        ren_gnt, ren_rvalid;
  logic [7:0]  ren_rdata;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  sprite_mem_arbiter #(.IDX_W(8), .ATTR_W(4), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_idx(cpu_idx), .cpu_attr(cpu_attr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .ren_req(ren_req), .ren_addr(ren_addr),
    .ren_gnt(ren_gnt), .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM, one cycle read latency.
  logic [7:0] ram [4096];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic        rst, re, we;
    logic [7:0]  idx;
    logic [3:0]  attr;
    logic [7:0]  wd;
    logic        rreq;
    logic [11:0] raddr;
    logic        e_stall, e_re, e_we, e_gnt, e_rrv, e_crv;
    logic [11:0] e_addr;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] shadow [4096];
  logic [7:0] cpu_q[$];
  logic [7:0] ren_q[$];
  int         n_err = 0;
  int         n_chk = 0;

  task automatic add(input logic rst_i, input logic re, input logic we,
                     input logic [7:0] idx, input logic [3:0] attr, input logic [7:0] wd,
                     input logic rreq, input logic [11:0] raddr,
                     input logic e_stall, input logic e_re, input logic e_we,
                     input logic e_gnt, input logic e_rrv, input logic e_crv,
                     input logic [11:0] e_addr, input logic [7:0] e_rdata);
    vec_t v;
    v.rst = rst_i; v.re = re; v.we = we; v.idx = idx; v.attr = attr; v.wd = wd;
    v.rreq = rreq; v.raddr = raddr;
    v.e_stall = e_stall; v.e_re = e_re; v.e_we = e_we; v.e_gnt = e_gnt;
    v.e_rrv = e_rrv; v.e_crv = e_crv; v.e_addr = e_addr; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_idx = '0; cpu_attr = '0;
    cpu_wdata = '0; ren_req = 1'b0; ren_addr = '0;

    //   rst re we idx    attr  wd     rq raddr    st mre mwe gnt rrv crv addr     rdata
    add(1, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
    add(1, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
    // uncontended write, then read back over two cycles
    add(0, 0, 1, 8'h12, 4'h3, 8'hA5, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'h123, 8'h00);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 0, 12'h000, 1, 1, 0, 0, 0, 0, 12'h123, 8'h00);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 1, 12'h000, 8'hA5);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'hA5);
    // contention: renderer wins twice, then the starved CPU is forced through
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 1, 1, 0, 1, 0, 0, 12'h456, 8'hA5);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 1, 0, 0, 0, 1, 0, 12'h000, 8'hA5);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 1, 1, 0, 1, 0, 0, 12'h456, 8'hA5);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 1, 0, 0, 0, 1, 0, 12'h000, 8'hA5);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 1, 1, 0, 0, 0, 0, 12'h123, 8'hA5);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 1, 12'h456, 0, 0, 0, 0, 0, 1, 12'h000, 8'hA5);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 1, 12'h456, 0, 1, 0, 1, 0, 0, 12'h456, 8'hA5);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 1, 0, 12'h000, 8'hA5);
    // reset during CPU_RD drops the read
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 0, 12'h000, 1, 1, 0, 0, 0, 0, 12'h123, 8'hA5);
    add(1, 1, 0, 8'h12, 4'h3, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
    // re and we together behave as a write
    add(0, 1, 1, 8'h12, 4'h3, 8'h3C, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'h123, 8'h00);
    add(0, 1, 0, 8'h12, 4'h3, 8'h00, 0, 12'h000, 1, 1, 0, 0, 0, 0, 12'h123, 8'h00);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 1, 12'h000, 8'h3C);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h3C);
    // CPU write stalled by the renderer, then renderer reads the new value
    add(0, 0, 1, 8'hAB, 4'hC, 8'h77, 1, 12'hABC, 1, 1, 0, 1, 0, 0, 12'hABC, 8'h3C);
    add(0, 0, 1, 8'hAB, 4'hC, 8'h77, 0, 12'h000, 1, 0, 0, 0, 1, 0, 12'h000, 8'h3C);
    add(0, 0, 1, 8'hAB, 4'hC, 8'h77, 0, 12'h000, 0, 0, 1, 0, 0, 0, 12'hABC, 8'h3C);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 1, 12'hABC, 0, 1, 0, 1, 0, 0, 12'hABC, 8'h3C);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 1, 0, 12'h000, 8'h3C);
    add(0, 0, 0, 8'h00, 4'h0, 8'h00, 0, 12'h000, 0, 0, 0, 0, 0, 0, 12'h000, 8'h3C);

    for (int c = 0; c < vecs.size(); c++) begin
      vec_t v;
      v = vecs[c];
      @(posedge clk);
      #1;
      rst = v.rst; cpu_re = v.re; cpu_we = v.we; cpu_idx = v.idx; cpu_attr = v.attr;
      cpu_wdata = v.wd; ren_req = v.rreq; ren_addr = v.raddr;
      if (v.rst) begin
        cpu_q.delete();
        ren_q.delete();
      end
      if (v.e_re && v.e_gnt) ren_q.push_back(shadow[v.raddr]);
      if (v.e_re && !v.e_gnt) cpu_q.push_back(shadow[{v.idx, v.attr}]);
      if (v.e_we) shadow[{v.idx, v.attr}] = v.wd;

      @(negedge clk);
      chk("cpu_stall",  c, 32'(cpu_stall),  32'(v.e_stall));
      chk("mem_re",     c, 32'(mem_re),     32'(v.e_re));
      chk("mem_we",     c, 32'(mem_we),     32'(v.e_we));
      chk("ren_gnt",    c, 32'(ren_gnt),    32'(v.e_gnt));
      chk("ren_rvalid", c, 32'(ren_rvalid), 32'(v.e_rrv));
      chk("cpu_rvalid", c, 32'(cpu_rvalid), 32'(v.e_crv));
      chk("cpu_rdata",  c, 32'(cpu_rdata),  32'(v.e_rdata));
      if (v.e_re || v.e_we) chk("mem_addr", c, 32'(mem_addr), 32'(v.e_addr));
      if (v.e_we) chk("mem_wdata", c, 32'(mem_wdata), 32'(v.wd));

      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_sb_unexpected", c, 32'(1), 32'(0));
        else chk("cpu_sb_data", c, 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (ren_rvalid) begin
        if (ren_q.size() == 0) chk("ren_sb_unexpected", c, 32'(1), 32'(0));
        else chk("ren_sb_data", c, 32'(ren_rdata), 32'(ren_q.pop_front()));
      end
    end

    chk("cpu_sb_leftover", vecs.size(), 32'(cpu_q.size()), 32'(0));
    chk("ren_sb_leftover", vecs.size(), 32'(ren_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
